// File: rtl/audio_pkg.sv
// Shared types and constants for the I2S DAC serializer path.
package audio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    SHIFT,
    PAD
  } fsm_state_e;

  localparam logic LR_LEFT     = 1'b0;
  localparam int   SYNC_STAGES = 2;

endpackage

// File: rtl/audio_dac_serializer_if.sv
// Stereo frame valid/ready source bundle.
interface audio_dac_serializer_if #(
  parameter int DATA_WIDTH = 16
);

  logic [DATA_WIDTH-1:0] s_left;
  logic [DATA_WIDTH-1:0] s_right;
  logic                  s_valid;
  logic                  s_ready;

  modport master (
    output s_left,
    output s_right,
    output s_valid,
    input  s_ready
  );

  modport slave (
    input  s_left,
    input  s_right,
    input  s_valid,
    output s_ready
  );

endinterface

// File: rtl/audio_frame_fifo.sv
// Synchronous show-ahead FIFO of {left,right} frames with level, full and empty.
module audio_frame_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_push;
  logic             w_pop;

  // Full/empty come from registered level, so a pop never frees space for a same-cycle push.
  assign full   = (r_level == (AW+1)'(DEPTH));
  assign empty  = (r_level == '0);
  assign w_push = push & ~full;
  assign w_pop  = pop & ~empty;
  assign rdata  = r_mem[r_rd_ptr];
  assign level  = r_level;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/audio_dac_serializer.sv
// I2S transmitter, bit-clock slave: buffers stereo frames and shifts them MSB-first onto AUD_DACDAT.
module audio_dac_serializer
  import audio_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  audio_dac_serializer_if.slave         src,
  input  logic                          aud_bclk,
  input  logic                          aud_daclrck,
  output logic                          aud_dacdat,
  output logic                          underflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

  logic [SYNC_STAGES-1:0]  r_bclk_sync;
  logic [SYNC_STAGES-1:0]  r_lr_sync;
  logic                    r_bclk_prev;
  logic                    r_lr_smp;

  fsm_state_e              r_state;
  logic                    r_chan;
  logic [DATA_WIDTH-1:0]   r_sh_l;
  logic [DATA_WIDTH-1:0]   r_sh_r;
  logic [DATA_WIDTH-1:0]   r_shift;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_dacdat;

  logic                    w_bclk;
  logic                    w_lr;
  logic                    w_bclk_fall;
  logic                    w_lr_edge;
  logic                    w_enter_left;
  logic                    w_enter_right;
  logic [DATA_WIDTH-1:0]   w_word;
  logic [2*DATA_WIDTH-1:0] w_head;
  logic                    w_full;
  logic                    w_empty;

  audio_frame_fifo #(
    .WIDTH (2*DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (src.s_valid),
    .wdata   ({src.s_left, src.s_right}),
    .pop     (w_enter_left),
    .rdata   (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (fifo_level)
  );

  assign src.s_ready = ~w_full;

  assign w_bclk        = r_bclk_sync[SYNC_STAGES-1];
  assign w_lr          = r_lr_sync[SYNC_STAGES-1];
  assign w_bclk_fall   = r_bclk_prev & ~w_bclk;
  assign w_lr_edge     = w_bclk_fall & (w_lr != r_lr_smp);
  // A right-channel edge only matters once a left edge has started framing.
  assign w_enter_left  = w_lr_edge & (w_lr == LR_LEFT);
  assign w_enter_right = w_lr_edge & (w_lr != LR_LEFT) & (r_state != IDLE);
  assign w_word        = (r_chan == LR_LEFT) ? r_sh_l : r_sh_r;
  assign underflow     = w_enter_left & w_empty;
  assign aud_dacdat    = r_dacdat;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bclk_sync <= '0;
      r_lr_sync   <= '0;
      r_bclk_prev <= 1'b0;
      r_lr_smp    <= LR_LEFT;
    end else begin
      r_bclk_sync <= {r_bclk_sync[SYNC_STAGES-2:0], aud_bclk};
      r_lr_sync   <= {r_lr_sync[SYNC_STAGES-2:0], aud_daclrck};
      r_bclk_prev <= w_bclk;
      if (w_bclk_fall) begin
        r_lr_smp <= w_lr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state  <= IDLE;
      r_chan   <= LR_LEFT;
      r_sh_l   <= '0;
      r_sh_r   <= '0;
      r_shift  <= '0;
      r_cnt    <= '0;
      r_dacdat <= 1'b0;
    end else if (w_bclk_fall) begin
      // An LR edge wins in every state, which also truncates a word cut short by a short half-frame.
      if (w_enter_left || w_enter_right) begin
        r_state  <= DELAY;
        r_chan   <= w_lr;
        r_dacdat <= 1'b0;
        if (w_enter_left) begin
          {r_sh_l, r_sh_r} <= w_empty ? '0 : w_head;
        end
      end else begin
        unique case (r_state)
          DELAY: begin
            r_dacdat <= w_word[DATA_WIDTH-1];
            r_shift  <= {w_word[DATA_WIDTH-2:0], 1'b0};
            r_cnt    <= CNT_W'(1);
            r_state  <= SHIFT;
          end
          SHIFT: begin
            if (r_cnt == CNT_W'(DATA_WIDTH)) begin
              r_dacdat <= 1'b0;
              r_state  <= PAD;
            end else begin
              r_dacdat <= r_shift[DATA_WIDTH-1];
              r_shift  <= {r_shift[DATA_WIDTH-2:0], 1'b0};
              r_cnt    <= r_cnt + CNT_W'(1);
            end
          end
          default: begin
            r_dacdat <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_audio_dac_serializer.sv
// Directed bench for audio_dac_serializer: frame vectors, FIFO fill/drain, same-cycle push/pop, mid-word reset.
module tb_audio_dac_serializer;

  localparam int DW = 16;
  localparam int FD = 4;
  localparam int LW = $clog2(FD) + 1;

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    bit            push;
    logic [DW-1:0] exp_l;
    logic [DW-1:0] exp_r;
    int            exp_uf;
  } vec_t;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          aud_bclk;
  logic          aud_daclrck;
  logic          aud_dacdat;
  logic          underflow;
  logic [LW-1:0] fifo_level;

  int   n_vec    = 0;
  int   n_err    = 0;
  int   uf_count = 0;
  logic cap [64];

  audio_dac_serializer_if #(.DATA_WIDTH(DW)) src_if ();

  audio_dac_serializer #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .src         (src_if.slave),
    .aud_bclk    (aud_bclk),
    .aud_daclrck (aud_daclrck),
    .aud_dacdat  (aud_dacdat),
    .underflow   (underflow),
    .fifo_level  (fifo_level)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (underflow === 1'b1) uf_count++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One BCLK period per slot: fall (with LRCK update), 8 clk low, rise + sample, 8 clk high.
  task automatic slots(input int first, input int n, input logic lr);
    for (int k = 0; k < n; k++) begin
      aud_bclk    = 1'b0;
      aud_daclrck = lr;
      repeat (8) @(negedge clk);
      aud_bclk        = 1'b1;
      cap[first + k]  = aud_dacdat;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic frame();
    slots(0, 32, 1'b0);
    slots(32, 32, 1'b1);
  endtask

  function automatic logic [DW-1:0] word_at(input int base);
    logic [DW-1:0] w;
    for (int b = 0; b < DW; b++) w[DW-1-b] = cap[base + 1 + b];
    return w;
  endfunction

  function automatic logic pad_bits();
    logic any = cap[0] | cap[32];
    for (int i = 17; i < 32; i++) any = any | cap[i] | cap[i + 32];
    return any;
  endfunction

  task automatic check_frame(input string name, input logic [DW-1:0] l, input logic [DW-1:0] r);
    check({name, " left word"}, 32'(word_at(0)), 32'(l));
    check({name, " right word"}, 32'(word_at(32)), 32'(r));
    check({name, " pad slots"}, 32'(pad_bits()), 32'd0);
  endtask

  task automatic push_frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    bit done = 1'b0;
    src_if.s_left  = l;
    src_if.s_right = r;
    src_if.s_valid = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      if (src_if.s_ready === 1'b1) done = 1'b1;
      @(negedge clk);
    end
    src_if.s_valid = 1'b0;
    check("push accepted", 32'(done), 32'd1);
  endtask

  initial begin
    vec_t          vec [6];
    logic [DW-1:0] fl [5];
    logic [DW-1:0] fr [5];
    int            uf0;
    logic          any;

    vec[0] = '{16'hA5C3, 16'h0F0F, 1'b1, 16'hA5C3, 16'h0F0F, 0};
    vec[1] = '{16'h8001, 16'h7FFE, 1'b1, 16'h8001, 16'h7FFE, 0};
    vec[2] = '{16'h0000, 16'hFFFF, 1'b1, 16'h0000, 16'hFFFF, 0};
    vec[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1};
    vec[4] = '{16'h1234, 16'hABCD, 1'b1, 16'h1234, 16'hABCD, 0};
    vec[5] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1};
    fl = '{16'hC001, 16'h5A5A, 16'hFFFF, 16'h8000, 16'hDEAD};
    fr = '{16'h300C, 16'hA5A5, 16'h0001, 16'h7FFF, 16'hBEEF};

    reset_n        = 1'b0;
    aud_bclk       = 1'b1;
    aud_daclrck    = 1'b1;
    src_if.s_valid = 1'b0;
    src_if.s_left  = '0;
    src_if.s_right = '0;
    repeat (3) @(negedge clk);
    check("reset dacdat", 32'(aud_dacdat), 32'd0);
    check("reset s_ready", 32'(src_if.s_ready), 32'd1);
    check("reset level", 32'(fifo_level), 32'd0);
    check("reset underflow", 32'(underflow), 32'd0);
    reset_n = 1'b1;
    slots(0, 2, 1'b1);
    check("no underflow while idle", 32'(uf_count), 32'd0);

    for (int v = 0; v < 6; v++) begin
      if (vec[v].push) push_frame(vec[v].l, vec[v].r);
      uf0 = uf_count;
      frame();
      check_frame($sformatf("vec%0d", v), vec[v].exp_l, vec[v].exp_r);
      check($sformatf("vec%0d underflow pulses", v), 32'(uf_count - uf0), 32'(vec[v].exp_uf));
    end

    // Fill past capacity with LRCK idle; the fifth frame waits for a pop.
    for (int k = 0; k < 5; k++) begin
      src_if.s_left  = fl[k];
      src_if.s_right = fr[k];
      src_if.s_valid = 1'b1;
      @(negedge clk);
      check($sformatf("fill%0d level", k), 32'(fifo_level), (k < 4) ? 32'(k + 1) : 32'd4);
      check($sformatf("fill%0d s_ready", k), 32'(src_if.s_ready), (k < 3) ? 32'd1 : 32'd0);
    end
    frame();
    src_if.s_valid = 1'b0;
    check("held frame pushed after pop", 32'(fifo_level), 32'd4);
    check_frame("fill drain0", fl[0], fr[0]);
    for (int k = 1; k < 5; k++) begin
      frame();
      check_frame($sformatf("fill drain%0d", k), fl[k], fr[k]);
      check($sformatf("drain%0d level", k), 32'(fifo_level), 32'(4 - k));
    end

    // Push and pop in the same clk at level 1.
    push_frame(16'h1357, 16'h2468);
    check("pp level before", 32'(fifo_level), 32'd1);
    uf0 = uf_count;
    aud_bclk    = 1'b0;
    aud_daclrck = 1'b0;
    repeat (2) @(negedge clk);
    src_if.s_left  = 16'h9ABC;
    src_if.s_right = 16'hDEF0;
    src_if.s_valid = 1'b1;
    @(negedge clk);
    src_if.s_valid = 1'b0;
    check("pp level after", 32'(fifo_level), 32'd1);
    check("pp s_ready", 32'(src_if.s_ready), 32'd1);
    check("pp no underflow", 32'(uf_count - uf0), 32'd0);
    repeat (5) @(negedge clk);
    aud_bclk = 1'b1;
    cap[0]   = aud_dacdat;
    repeat (8) @(negedge clk);
    slots(1, 31, 1'b0);
    slots(32, 32, 1'b1);
    check_frame("pp popped", 16'h1357, 16'h2468);
    frame();
    check_frame("pp pushed", 16'h9ABC, 16'hDEF0);
    check("pp drained level", 32'(fifo_level), 32'd0);

    // Reset during left bit 7; the queued frame is lost and the next right edge is ignored.
    push_frame(16'hFACE, 16'h0123);
    push_frame(16'h4321, 16'h8765);
    uf0 = uf_count;
    slots(0, 9, 1'b0);
    aud_bclk = 1'b0;
    repeat (4) @(negedge clk);
    check("left bit7 before reset", 32'(aud_dacdat), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    check("mid reset dacdat", 32'(aud_dacdat), 32'd0);
    check("mid reset s_ready", 32'(src_if.s_ready), 32'd1);
    check("mid reset level", 32'(fifo_level), 32'd0);
    check("mid reset underflow", 32'(underflow), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    aud_bclk = 1'b1;
    cap[9]   = aud_dacdat;
    repeat (8) @(negedge clk);
    slots(10, 22, 1'b0);
    slots(32, 32, 1'b1);
    any = 1'b0;
    for (int i = 9; i < 64; i++) any = any | cap[i];
    check("silent after reset", 32'(any), 32'd0);
    check("no pop after reset", 32'(uf_count - uf0), 32'd0);
    push_frame(16'h0F1E, 16'h2D3C);
    frame();
    check_frame("restart", 16'h0F1E, 16'h2D3C);
    check("restart level", 32'(fifo_level), 32'd0);
    check("restart underflow", 32'(uf_count - uf0), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
